// File: rtl/z80_bus_ctrl_if.sv
// ==================================================================
// z80_bus_ctrl_if : 68K bus signals seen by the Z80 control registers
// Rev 1.0
// ==================================================================
`default_nettype none

interface z80_bus_ctrl_if;
   logic [31:0] M68_addr;
   logic        M68_as;
   logic        M68_rw;
   logic        M68_uds;
   logic        M68_lds;
   logic [15:0] M68_data_out;
   logic [15:0] M68_data_in;
   logic        M68_dtack;
   logic        ctrl_sel;

   modport master (
      output M68_addr, M68_as, M68_rw, M68_uds, M68_lds, M68_data_out,
      input  M68_data_in, M68_dtack, ctrl_sel
   );

   modport slave (
      input  M68_addr, M68_as, M68_rw, M68_uds, M68_lds, M68_data_out,
      output M68_data_in, M68_dtack, ctrl_sel
   );
endinterface

`default_nettype wire

// File: rtl/z80_bus_ctrl.sv
// ==================================================================
// z80_bus_ctrl : 68K-visible Z80 BUSREQ/RESET registers and grant logic
// Rev 1.0
// ==================================================================
`default_nettype none

module z80_bus_ctrl #(
   parameter logic [23:0] BUSREQ_ADDR = 24'hA11100,
   parameter logic [23:0] RESET_ADDR  = 24'hA11200,
   parameter int          RESET_MIN   = 16,
   parameter int          SYNC_STAGES = 2
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   z80_bus_ctrl_if.slave     m68,
   input  wire logic         Z80_busack_n,
   output logic              Z80_busreq_n,
   output logic              Z80_reset_n,
   output logic              bus_granted
);

   localparam int              CNT_W   = $clog2(RESET_MIN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESET_MIN);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               dtack_nxt, sel_nxt;
   logic [15:0]        rdata_nxt;
   logic               busreq_reg, busreq_nxt;
   logic               reset_reg, reset_nxt;
   logic [CNT_W-1:0]   rst_cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic               busack_s;
   logic               hit_busreq, hit_reset;
   logic               unused_bits;

   assign hit_busreq   = (m68.M68_addr[23:1] == BUSREQ_ADDR[23:1]);
   assign hit_reset    = (m68.M68_addr[23:1] == RESET_ADDR[23:1]);
   assign busack_s     = sync[SYNC_STAGES-1];
   assign Z80_busreq_n = ~busreq_reg;
   assign unused_bits  = &{m68.M68_addr[31:24], m68.M68_addr[0], m68.M68_lds,
                           m68.M68_data_out[15:9], m68.M68_data_out[7:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         m68.M68_dtack   <= 1'b1;
         m68.ctrl_sel    <= 1'b0;
         m68.M68_data_in <= 16'h0000;
      end else begin
         state           <= state_nxt;
         m68.M68_dtack   <= dtack_nxt;
         m68.ctrl_sel    <= sel_nxt;
         m68.M68_data_in <= rdata_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      dtack_nxt  = m68.M68_dtack;
      sel_nxt    = m68.ctrl_sel;
      rdata_nxt  = m68.M68_data_in;
      busreq_nxt = busreq_reg;
      reset_nxt  = reset_reg;
      case (state)
         IDLE: begin
            if (!m68.M68_as && (hit_busreq || hit_reset)) begin
               sel_nxt   = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (m68.M68_as) begin
               sel_nxt   = 1'b0;
               state_nxt = IDLE;
            end else begin
               dtack_nxt = 1'b0;
               state_nxt = ACK;
               if (m68.M68_rw) begin
                  rdata_nxt = hit_busreq ? {7'b0, ~bus_granted, 8'h00} : 16'h0000;
               end else if (!m68.M68_uds) begin
                  // Only the upper byte carries the control bit; LDS-only writes are acked and dropped.
                  if (hit_busreq)
                     busreq_nxt = m68.M68_data_out[8];
                  else if (hit_reset)
                     reset_nxt = m68.M68_data_out[8];
               end
            end
         end
         ACK: begin
            if (m68.M68_as) begin
               dtack_nxt = 1'b1;
               sel_nxt   = 1'b0;
               rdata_nxt = 16'h0000;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busreq_reg  <= 1'b0;
         reset_reg   <= 1'b0;
         rst_cnt     <= '0;
         Z80_reset_n <= 1'b0;
         sync        <= '1;
         bus_granted <= 1'b0;
      end else begin
         busreq_reg <= busreq_nxt;
         reset_reg  <= reset_nxt;
         sync       <= {sync[SYNC_STAGES-2:0], Z80_busack_n};
         // A fresh assertion restarts the minimum-low window; an early release waits it out.
         if (reset_reg && !reset_nxt)
            rst_cnt <= '0;
         else if (!Z80_reset_n && (rst_cnt != CNT_MAX))
            rst_cnt <= rst_cnt + 1'b1;
         if (!reset_nxt)
            Z80_reset_n <= 1'b0;
         else if (rst_cnt == CNT_MAX)
            Z80_reset_n <= 1'b1;
         bus_granted <= busreq_reg & ~busack_s & Z80_reset_n;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_z80_bus_ctrl.sv
// ==================================================================
// tb_z80_bus_ctrl : randomized self-checking bench for z80_bus_ctrl
// Rev 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_z80_bus_ctrl;
   localparam int RESET_MIN   = 16;
   localparam int SYNC_STAGES = 2;
   localparam logic [31:0] A_BUSREQ = 32'h00A11100;
   localparam logic [31:0] A_RESET  = 32'h00A11200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busack_n = 1'b1;
   logic busreq_n, reset_n, granted;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   // reference model: register contents plus the cycles at which they last changed
   bit   m_busreq, m_reset;
   int   assert_cyc, rel_cyc, busreq_cyc;

   z80_bus_ctrl_if bus ();

   z80_bus_ctrl #(
      .RESET_MIN   (RESET_MIN),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m68          (bus),
      .Z80_busack_n (busack_n),
      .Z80_busreq_n (busreq_n),
      .Z80_reset_n  (reset_n),
      .bus_granted  (granted)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic idle_bus();
      bus.M68_as = 1'b1; bus.M68_uds = 1'b1; bus.M68_lds = 1'b1; bus.M68_rw = 1'b1;
      bus.M68_addr = '0; bus.M68_data_out = '0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_bus();
      busack_n = 1'b1;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      step(1);
      m_busreq = 0; m_reset = 0; assert_cyc = 0; rel_cyc = 0; busreq_cyc = 0;
   endtask

   task automatic bus_start(input logic rw, input logic [31:0] addr, input logic uds,
                            input logic lds, input logic [15:0] wd);
      bus.M68_rw = rw; bus.M68_addr = addr; bus.M68_uds = uds; bus.M68_lds = lds;
      bus.M68_data_out = wd; bus.M68_as = 1'b0;
   endtask

   task automatic bus_wait_ack(output int lat, output logic [15:0] rd, output bit ok);
      lat = 0; rd = '0; ok = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (bus.M68_dtack === 1'b0) begin
            lat = i; rd = bus.M68_data_in; ok = 1;
            break;
         end
      end
   endtask

   task automatic bus_end(output bit ok);
      idle_bus();
      ok = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.M68_dtack === 1'b1) begin ok = 1; break; end
      end
   endtask

   task automatic bus_cycle(input logic rw, input logic [31:0] addr, input logic uds,
                            input logic lds, input logic [15:0] wd, output int lat,
                            output logic [15:0] rd, output int ack_cyc, output bit ok);
      bit ok1, ok2;
      bus_start(rw, addr, uds, lds, wd);
      bus_wait_ack(lat, rd, ok1);
      ack_cyc = cyc;
      bus_end(ok2);
      ok = ok1 & ok2;
   endtask

   function automatic logic [15:0] wdata(input bit b);
      return (16'($urandom) & 16'hFEFF) | {7'b0, b, 8'h00};
   endfunction

   // 0 = low, 1 = high, 2 = still inside the allowed release window
   function automatic int reset_state(input int t);
      int rise;
      if (!m_reset) return 0;
      rise = (assert_cyc + RESET_MIN > rel_cyc) ? assert_cyc + RESET_MIN : rel_cyc;
      if (t >= rise + 4) return 1;
      if (t < assert_cyc + RESET_MIN) return 0;
      return 2;
   endfunction

   function automatic int grant_state(input int t);
      int rs;
      if (t < busreq_cyc + 2) return 2;
      if (!m_busreq) return 0;
      rs = reset_state(t - 1);
      return rs;
   endfunction

   task automatic test_reset();
      logic [20:0] got;
      do_reset();
      got = {reset_n, busreq_n, bus.M68_dtack, granted, bus.ctrl_sel, bus.M68_data_in};
      total++;
      if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
         bad++; $display("FAIL reset_values got=%h want=%h", got, {5'b01100, 16'h0000});
      end
   endtask

   task automatic test_grant_in_reset();
      int lat, ac; logic [15:0] rd; bit ok;
      bus_cycle(1'b0, A_BUSREQ, 1'b0, 1'b0, wdata(1), lat, rd, ac, ok);
      busack_n = 1'b0;
      step(6);
      total++;
      if (granted !== 1'b0 || busreq_n !== 1'b0) begin
         bad++; $display("FAIL grant_in_reset got granted=%b busreq_n=%b want 0 0", granted, busreq_n);
      end
      bus_cycle(1'b1, A_BUSREQ, 1'b0, 1'b0, 16'h0, lat, rd, ac, ok);
      total++;
      if (!ok || rd !== 16'h0100) begin
         bad++; $display("FAIL read_in_reset got=%h ok=%0d want=0100", rd, ok);
      end
      bus_cycle(1'b0, A_BUSREQ, 1'b0, 1'b0, wdata(0), lat, rd, ac, ok);
      busack_n = 1'b1;
   endtask

   task automatic test_reset_release();
      int lat, ac, rise; logic [15:0] rd; bit ok;
      do_reset();
      step(2);
      bus_cycle(1'b0, A_RESET, 1'b0, 1'b0, wdata(1), lat, rd, ac, ok);
      total++;
      if (!ok || lat != 2) begin
         bad++; $display("FAIL reset_write_latency got=%0d ok=%0d want=2", lat, ok);
      end
      m_reset = 1; rel_cyc = ac;
      rise = -1;
      for (int i = 0; i < 40; i++) begin
         if (reset_n === 1'b1) begin rise = cyc; break; end
         step(1);
      end
      total++;
      if (rise < RESET_MIN || rise > RESET_MIN + 3) begin
         bad++; $display("FAIL reset_stretch got rise=%0d want %0d..%0d", rise, RESET_MIN, RESET_MIN + 3);
      end
   endtask

   task automatic test_busreq();
      int lat, ac, t0, dl; logic [15:0] rd; bit ok;
      bus_cycle(1'b0, A_BUSREQ, 1'b0, 1'($urandom), wdata(1), lat, rd, ac, ok);
      m_busreq = 1; busreq_cyc = ac;
      total++;
      if (!ok || busreq_n !== 1'b0) begin
         bad++; $display("FAIL busreq_pin got=%b ok=%0d want=0", busreq_n, ok);
      end
      bus_cycle(1'b1, A_BUSREQ, 1'b0, 1'b0, 16'h0, lat, rd, ac, ok);
      total++;
      if (!ok || rd !== 16'h0100) begin
         bad++; $display("FAIL read_before_ack got=%h want=0100", rd);
      end
      step(5);
      busack_n = 1'b0;
      t0 = cyc; dl = -1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (granted === 1'b1) begin dl = cyc - t0; break; end
      end
      total++;
      if (dl != SYNC_STAGES + 1) begin
         bad++; $display("FAIL grant_delay got=%0d want=%0d", dl, SYNC_STAGES + 1);
      end
      bus_cycle(1'b1, A_BUSREQ, 1'b0, 1'b0, 16'h0, lat, rd, ac, ok);
      total++;
      if (!ok || rd !== 16'h0000) begin
         bad++; $display("FAIL read_after_ack got=%h want=0000", rd);
      end
   endtask

   task automatic test_release();
      int lat; logic [15:0] rd; bit ok;
      bus_start(1'b0, A_BUSREQ, 1'b0, 1'b0, wdata(0));
      bus_wait_ack(lat, rd, ok);
      m_busreq = 0; busreq_cyc = cyc;
      step(1);
      total++;
      if (!ok || granted !== 1'b0 || busreq_n !== 1'b1) begin
         bad++; $display("FAIL release got granted=%b busreq_n=%b want 0 1", granted, busreq_n);
      end
      bus_end(ok);
      busack_n = 1'b1;
   endtask

   task automatic test_byte_abort();
      int lat, ac; logic [15:0] rd; bit ok, seen;
      bus_cycle(1'b0, A_BUSREQ | 32'h1, 1'b1, 1'b0, 16'h0100, lat, rd, ac, ok);
      step(2);
      total++;
      if (!ok || lat != 2 || busreq_n !== 1'b1) begin
         bad++; $display("FAIL lds_busreq got lat=%0d busreq_n=%b want 2 1", lat, busreq_n);
      end
      bus_cycle(1'b0, A_RESET | 32'h1, 1'b1, 1'b0, 16'h0000, lat, rd, ac, ok);
      step(3);
      total++;
      if (!ok || lat != 2 || reset_n !== 1'b1) begin
         bad++; $display("FAIL lds_reset got lat=%0d reset_n=%b want 2 1", lat, reset_n);
      end
      bus_start(1'b0, A_BUSREQ, 1'b0, 1'b0, wdata(1));
      step(1);
      total++;
      if (bus.ctrl_sel !== 1'b1) begin
         bad++; $display("FAIL abort_sel got=%b want=1", bus.ctrl_sel);
      end
      idle_bus();
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         if (bus.M68_dtack !== 1'b1) seen = 1;
      end
      total++;
      if (seen || bus.ctrl_sel !== 1'b0 || busreq_n !== 1'b1) begin
         bad++; $display("FAIL abort got dtack_seen=%0d sel=%b busreq_n=%b want 0 0 1", seen, bus.ctrl_sel, busreq_n);
      end
   endtask

   task automatic test_nonhit();
      logic [31:0] addrs [5];
      bit seen;
      addrs = '{32'h00C00000, 32'h00A11000, 32'h00A11102, 32'h00A11202, 32'h00A11300};
      foreach (addrs[k]) begin
         bus_start(1'b0, addrs[k], 1'b0, 1'b0, wdata(1));
         seen = 0;
         for (int i = 0; i < 4; i++) begin
            step(1);
            if (bus.M68_dtack !== 1'b1 || bus.ctrl_sel !== 1'b0) seen = 1;
         end
         idle_bus();
         step(1);
         total++;
         if (seen || busreq_n !== 1'b1) begin
            bad++; $display("FAIL nonhit addr=%h got seen=%0d busreq_n=%b want 0 1", addrs[k], seen, busreq_n);
         end
      end
   endtask

   task automatic test_random();
      int lat, ac, op, rs, gs; logic [15:0] rd, want; bit ok, b;
      logic [31:0] base;
      busack_n = 1'b0;
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 6);
         b  = 1'($urandom);
         base = (op == 2 || op == 3 || op == 5) ? A_RESET : A_BUSREQ;
         if (op == 6 && b) base = A_RESET;
         base = {8'($urandom), base[23:1], 1'($urandom)};
         if (op == 3 && $urandom_range(0, 3) != 0) op = 2;
         case (op)
            0, 1: bus_cycle(1'b0, base, 1'b0, 1'($urandom), wdata(b), lat, rd, ac, ok);
            2:    bus_cycle(1'b0, base, 1'b0, 1'b0, wdata(1), lat, rd, ac, ok);
            3:    bus_cycle(1'b0, base, 1'b0, 1'b0, wdata(0), lat, rd, ac, ok);
            6:    bus_cycle(1'b0, base, 1'b1, 1'b0, 16'($urandom), lat, rd, ac, ok);
            default: bus_cycle(1'b1, base, 1'b0, 1'b0, 16'($urandom), lat, rd, ac, ok);
         endcase
         total++;
         if (!ok || lat != 2) begin
            bad++; $display("FAIL rnd_ack op=%0d got lat=%0d ok=%0d want 2", op, lat, ok);
         end
         if (op == 0 || op == 1) begin
            m_busreq = b; busreq_cyc = ac;
         end else if (op == 2 || op == 3) begin
            if (m_reset && op == 3) assert_cyc = ac;
            if (!m_reset && op == 2) rel_cyc = ac;
            m_reset = (op == 2);
         end else if (op == 4 || op == 5) begin
            gs = grant_state(ac - 1);
            want = (op == 5) ? 16'h0000 : {7'b0, ~gs[0], 8'h00};
            if (op == 5 || gs != 2) begin
               total++;
               if (rd !== want) begin
                  bad++; $display("FAIL rnd_read op=%0d got=%h want=%h", op, rd, want);
               end
            end
         end
         step($urandom_range(0, 5));
         total++;
         if (busreq_n !== ~m_busreq) begin
            bad++; $display("FAIL rnd_busreq_pin got=%b want=%b", busreq_n, ~m_busreq);
         end
         rs = reset_state(cyc);
         if (rs != 2) begin
            total++;
            if (reset_n !== rs[0]) begin
               bad++; $display("FAIL rnd_reset_pin got=%b want=%b", reset_n, rs[0]);
            end
         end
         gs = grant_state(cyc);
         if (gs != 2) begin
            total++;
            if (granted !== gs[0]) begin
               bad++; $display("FAIL rnd_grant got=%b want=%b", granted, gs[0]);
            end
         end
      end
      busack_n = 1'b1;
   endtask

   task automatic test_reset_async();
      int lat; logic [15:0] rd; bit ok;
      logic [18:0] got;
      bus_start(1'b1, A_BUSREQ, 1'b0, 1'b0, 16'h0);
      bus_wait_ack(lat, rd, ok);
      #2 rst_n = 1'b0;
      #1;
      got = {bus.M68_dtack, bus.ctrl_sel, reset_n, bus.M68_data_in};
      total++;
      if (!ok || got !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         bad++; $display("FAIL async_reset got=%h ok=%0d want=%h", got, ok, {3'b100, 16'h0000});
      end
      idle_bus();
      @(negedge clk); rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      idle_bus();
      test_reset();
      test_grant_in_reset();
      test_reset_release();
      test_busreq();
      test_release();
      test_byte_abort();
      test_nonhit();
      do_reset();
      test_random();
      test_reset_async();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
